// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM chain: gate-driver state encoding and default widths.
// The duty-cycle generator's top also pulls its defaults from here.
package pwm_pkg;

  localparam int DT_W_DEF      = 4;
  localparam int DEAD_TIME_DEF = 2;

  // Bit positions of the one-hot state vector.
  localparam int ST_B_OFF   = 0;
  localparam int ST_B_LS_ON = 1;
  localparam int ST_B_DT_LH = 2;
  localparam int ST_B_HS_ON = 3;
  localparam int ST_B_DT_HL = 4;
  localparam int ST_B_FAULT = 5;

  typedef enum logic [5:0] {
    ST_OFF   = 6'b000001,
    ST_LS_ON = 6'b000010,
    ST_DT_LH = 6'b000100,
    ST_HS_ON = 6'b001000,
    ST_DT_HL = 6'b010000,
    ST_FAULT = 6'b100000
  } drv_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level signal.
// All stages clear to 0 on reset.
module sync_2ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Half-bridge gate driver: splits one PWM stream into complementary gate enables
// with break-before-make dead time and a latched, software-cleared fault state.
module pwm_deadtime_driver
  import pwm_pkg::*;
#(
  parameter int DT_W        = DT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            hs_out,
  output logic            ls_out,
  output logic            dt_active,
  output logic            fault_latched
);

  drv_state_e      state_q, state_d;
  logic            pwm_q, pwm_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic            fault_s;

  sync_2ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_fault_sync (
    .clk(clk),
    .rst(rst),
    .d  (fault_in),
    .q  (fault_s)
  );

  assign pwm_d = pwm_in;

  // Fault outranks everything, and only fault_clr leaves FAULT; en is ignored there.
  always_comb begin
    state_d = state_q;
    if (fault_s) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clr) state_d = ST_OFF;
    end else if (!en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:   state_d = pwm_q ? ST_DT_LH : ST_LS_ON;
        ST_LS_ON: if (pwm_q) state_d = ST_DT_LH;
        ST_DT_LH: begin
          if (!pwm_q)               state_d = ST_LS_ON;
          else if (dt_cnt_q == '0)  state_d = ST_HS_ON;
        end
        ST_HS_ON: if (!pwm_q) state_d = ST_DT_HL;
        ST_DT_HL: begin
          if (pwm_q)                state_d = ST_HS_ON;
          else if (dt_cnt_q == '0)  state_d = ST_LS_ON;
        end
        default:  state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
    end
  end

  // dead_time is captured only on entry, so a mid-window change waits for the next edge.
  always_comb begin
    dt_cnt_d = dt_cnt_q;
    if ((state_d == ST_DT_LH || state_d == ST_DT_HL) && state_d != state_q) begin
      dt_cnt_d = dead_time;
    end else if ((state_q == ST_DT_LH || state_q == ST_DT_HL) && dt_cnt_q != '0) begin
      dt_cnt_d = dt_cnt_q - DT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_cnt_q <= '0;
    end else begin
      dt_cnt_q <= dt_cnt_d;
    end
  end

  assign hs_out        = state_q[ST_B_HS_ON];
  assign ls_out        = state_q[ST_B_LS_ON];
  assign dt_active     = state_q[ST_B_DT_LH] | state_q[ST_B_DT_HL];
  assign fault_latched = state_q[ST_B_FAULT];

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed self-checking bench for the half-bridge dead-time gate driver.
module tb_pwm_deadtime_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pwm_in;
  logic [3:0] dead_time;
  logic       fault_in;
  logic       fault_clr;
  logic       hs_out;
  logic       ls_out;
  logic       dt_active;
  logic       fault_latched;

  int checks = 0;
  int errors = 0;
  int overlapCount = 0;

  pwm_deadtime_driver #(
    .DT_W       (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pwm_in       (pwm_in),
    .dead_time    (dead_time),
    .fault_in     (fault_in),
    .fault_clr    (fault_clr),
    .hs_out       (hs_out),
    .ls_out       (ls_out),
    .dt_active    (dt_active),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  // Gate overlap must never happen outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (hs_out && ls_out) overlapCount++;
      assert (!(hs_out && ls_out))
        else $error("[TB] FAIL overlap: hs_out=1 and ls_out=1 together, required never");
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic pwmV, input logic [3:0] dtV,
                               input logic faultV, input logic clrV);
    en        = enV;
    pwm_in    = pwmV;
    dead_time = dtV;
    fault_in  = faultV;
    fault_clr = clrV;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected {hs,ls,dt} after each edge of a 10-cycle, 50% period with dead_time=0.
  logic [2:0] periodExp [10] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b100,
                                 3'b100, 3'b001, 3'b010, 3'b010, 3'b010};

  initial begin
    int  dtCycles;
    logic hsSeen;
    logic reached;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    tick(2);
    checkOutput("reset_outputs", {hs_out, ls_out, dt_active, fault_latched}, 4'b0000);
    rst = 1'b0;

    // Enable with PWM low, then a rising PWM edge with dead_time=3.
    applyStimulus(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    tick(2);
    checkOutput("t2_ls_on_idle", {hs_out, ls_out, dt_active}, 3'b010);
    pwm_in = 1'b1;
    tick(1);
    checkOutput("t2_ls_still_on_e0", {hs_out, ls_out}, 2'b01);
    tick(1);
    checkOutput("t2_ls_off_e1", {hs_out, ls_out, dt_active}, 3'b001);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("t2_dt_window", {hs_out, ls_out, dt_active}, 3'b001);
    end
    tick(1);
    checkOutput("t2_hs_on_e5", {hs_out, ls_out, dt_active}, 3'b100);

    // Asynchronous reset from HS_ON, observed before any clock edge.
    rst = 1'b1;
    #1;
    checkOutput("t1_async_reset", {hs_out, ls_out, dt_active, fault_latched}, 4'b0000);
    tick(1);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(3);
    checkOutput("t1_recover_ls", {hs_out, ls_out}, 2'b01);

    // dead_time=0 with a 10-cycle 50% PWM; long run for the overlap monitor.
    for (int c = 0; c < 1020; c++) begin
      pwm_in = ((c % 10) < 5);
      tick(1);
      if (c < 20) checkOutput("t3_period", {hs_out, ls_out, dt_active}, periodExp[c % 10]);
    end
    pwm_in = 1'b0;
    tick(2);
    checkOutput("t3_no_overlap", overlapCount, 0);

    // A 3-cycle pulse shorter than dead_time=5 must be absorbed.
    dead_time = 4'd5;
    hsSeen = 1'b0;
    pwm_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) pwm_in = 1'b0;
      tick(1);
      if (hs_out) hsSeen = 1'b1;
      if (c == 3) checkOutput("t4_dt_before_abort", dt_active, 1'b1);
    end
    checkOutput("t4_ls_restored", {hs_out, ls_out, dt_active}, 3'b010);
    tick(3);
    checkOutput("t4_hs_never", hsSeen, 1'b0);

    // Fault during HS_ON.
    dead_time = 4'd1;
    pwm_in = 1'b1;
    tick(6);
    checkOutput("t5_hs_on", hs_out, 1'b1);
    fault_in = 1'b1;
    pwm_in   = 1'b0;
    tick(2);
    checkOutput("t5_not_early", fault_latched, 1'b0);
    tick(1);
    checkOutput("t5_fault_latched", {hs_out, ls_out, fault_latched}, 3'b001);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    tick(1);
    checkOutput("t5_clr_ignored", fault_latched, 1'b1);
    fault_in = 1'b0;
    tick(3);
    checkOutput("t5_still_fault", fault_latched, 1'b1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checkOutput("t5_off_after_clr", {hs_out, ls_out, dt_active, fault_latched}, 4'b0000);
    tick(1);
    checkOutput("t5_ls_on", {hs_out, ls_out}, 2'b01);

    // en drop during DT_LH, then re-enable with PWM high and a mid-window dead_time change.
    dead_time = 4'd3;
    pwm_in = 1'b1;
    tick(2);
    checkOutput("t6_in_dt_lh", dt_active, 1'b1);
    en = 1'b0;
    tick(1);
    checkOutput("t6_off", {hs_out, ls_out, dt_active}, 3'b000);
    en = 1'b1;
    tick(1);
    checkOutput("t6_reenter_dt", {hs_out, ls_out, dt_active}, 3'b001);
    dead_time = 4'd9;
    dtCycles = 1;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ls_out) begin
        checkOutput("t6_ls_during_dt", ls_out, 1'b0);
        break;
      end
      if (hs_out) begin
        reached = 1'b1;
        break;
      end
      if (dt_active) dtCycles++;
    end
    checkOutput("t6_hs_reached", reached, 1'b1);
    checkOutput("t6_full_dt_len", dtCycles, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
